// File: rtl/player_memory_init_pkg.sv
// Shared definitions for the starting player memory generator: record field
// widths, default balance, controller state encoding and record packing.
package player_memory_init_pkg;

    localparam int KEY_W   = 8;
    localparam int MONEY_W = 8;
    localparam int REC_W   = KEY_W + KEY_W + MONEY_W;

    localparam logic [MONEY_W-1:0] DEFAULT_START_MONEY = 8'h32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HASH,
        STORE,
        DONE
    } initStateT;

    // A record reads {private key, public key, money} from MS to LS byte.
    function automatic logic [REC_W-1:0] packRecord(
        input logic [KEY_W-1:0]   privKey,
        input logic [KEY_W-1:0]   pubKey,
        input logic [MONEY_W-1:0] money
    );
        return {privKey, pubKey, money};
    endfunction

endpackage

// File: rtl/player_memory_init_if.sv
// Request/result bus of player_memory_init. With MEM_WRITE_PORT_EN defined it
// also carries the registered write port for an external player RAM.
interface player_memory_init_if
    import player_memory_init_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int TABLE_DEPTH = 36
);
    logic                           start;
    logic [KEY_W*NUM_PLAYERS-1:0]   private_keys;
    logic [8*TABLE_DEPTH-1:0]       random_table;
    logic                           busy;
    logic                           done;
    logic [REC_W*NUM_PLAYERS-1:0]   starting_memory;

`ifdef MEM_WRITE_PORT_EN
    localparam int ADDR_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    logic                           mem_we;
    logic [ADDR_W-1:0]              mem_addr;
    logic [REC_W-1:0]               mem_wdata;

    modport master (
        output start, private_keys, random_table,
        input  busy, done, starting_memory, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  start, private_keys, random_table,
        output busy, done, starting_memory, mem_we, mem_addr, mem_wdata
    );
`else
    modport master (
        output start, private_keys, random_table,
        input  busy, done, starting_memory
    );

    modport slave (
        input  start, private_keys, random_table,
        output busy, done, starting_memory
    );
`endif

endinterface

// File: rtl/player_memory_init_pearson_hash_iter.sv
// Iterative Pearson hasher: HASH_ROUNDS table lookups starting from h=0,
// the first round is evaluated in the start cycle itself.
module pearson_hash_iter #(
    parameter int TABLE_DEPTH = 36,
    parameter int HASH_ROUNDS = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic [7:0]               i_key,
    input  logic [8*TABLE_DEPTH-1:0] i_table,
    output logic [7:0]               o_hash,
    output logic                     o_valid
);
    localparam int SEL_W = $clog2(8 * TABLE_DEPTH);

    logic [7:0]       r_hash;
    logic [7:0]       r_key;
    logic [31:0]      r_round;
    logic             r_running;
    logic             r_valid;

    logic [7:0]       w_hashIn;
    logic [7:0]       w_keyIn;
    logic [7:0]       w_roundIn;
    logic [7:0]       w_mix;
    logic [31:0]      w_idx;
    logic [SEL_W-1:0] w_base;
    logic [7:0]       w_entry;

    // On start the round-0 operands are taken straight from the inputs.
    always_comb begin
        w_hashIn  = i_start ? 8'd0 : r_hash;
        w_keyIn   = i_start ? i_key : r_key;
        w_roundIn = i_start ? 8'd0 : r_round[7:0];
        w_mix     = w_hashIn ^ w_keyIn ^ w_roundIn;
        w_idx     = {24'd0, w_mix} % 32'(TABLE_DEPTH);
        w_base    = SEL_W'(w_idx * 32'd8);
        w_entry   = i_table[w_base +: 8];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hash    <= 8'd0;
            r_key     <= 8'd0;
            r_round   <= 32'd0;
            r_running <= 1'b0;
            r_valid   <= 1'b0;
        end else if (i_start) begin
            r_key     <= i_key;
            r_hash    <= w_entry;
            r_round   <= 32'd1;
            r_running <= (HASH_ROUNDS > 1);
            r_valid   <= (HASH_ROUNDS == 1);
        end else if (r_running) begin
            r_hash  <= w_entry;
            r_round <= r_round + 32'd1;
            if (r_round == 32'(HASH_ROUNDS - 1)) begin
                r_running <= 1'b0;
                r_valid   <= 1'b1;
            end
        end
    end

    assign o_hash  = r_hash;
    assign o_valid = r_valid;

endmodule

// File: rtl/player_memory_init.sv
// Builds the starting player memory {priv, pub, money} for every player once per
// start pulse. MEM_WRITE_PORT_EN adds a registered per-record RAM write port.
module player_memory_init
    import player_memory_init_pkg::*;
#(
    parameter int                 NUM_PLAYERS = 2,
    parameter int                 TABLE_DEPTH = 36,
    parameter int                 HASH_ROUNDS = 8,
    parameter logic [MONEY_W-1:0] START_MONEY = DEFAULT_START_MONEY
) (
    input  logic                 clock,
    input  logic                 reset,
    player_memory_init_if.slave  bus
);
    localparam int ADDR_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    initStateT                    r_state;
    logic [ADDR_W-1:0]            r_player;
    logic [KEY_W-1:0]             r_keys [NUM_PLAYERS];
    logic [REC_W*NUM_PLAYERS-1:0] r_mem;
    logic                         r_busy;
    logic                         r_done;
`ifdef MEM_WRITE_PORT_EN
    logic                         r_memWe;
    logic [ADDR_W-1:0]            r_memAddr;
    logic [REC_W-1:0]             r_memWdata;
`endif

    logic                         w_hashStart;
    logic [KEY_W-1:0]             w_curKey;
    logic [7:0]                   w_hash;
    logic                         w_hashValid;
    logic [REC_W-1:0]             w_record;

    assign w_hashStart = (r_state == LOAD);
    assign w_curKey    = r_keys[r_player];
    assign w_record    = packRecord(w_curKey, w_hash, START_MONEY);

    pearson_hash_iter #(
        .TABLE_DEPTH (TABLE_DEPTH),
        .HASH_ROUNDS (HASH_ROUNDS)
    ) u_hash (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_hashStart),
        .i_key   (w_curKey),
        .i_table (bus.random_table),
        .o_hash  (w_hash),
        .o_valid (w_hashValid)
    );

    // The hasher finishes one cycle early, so HASH still spans HASH_ROUNDS cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_player <= '0;
            r_mem    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_keys[i] <= '0;
            end
`ifdef MEM_WRITE_PORT_EN
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
`endif
        end else begin
`ifdef MEM_WRITE_PORT_EN
            r_memWe <= 1'b0;
`endif
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            r_keys[i] <= bus.private_keys[(NUM_PLAYERS-1-i)*KEY_W +: KEY_W];
                        end
                        r_player <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    r_state <= HASH;
                end
                HASH: begin
                    if (w_hashValid) begin
                        r_state <= STORE;
`ifdef MEM_WRITE_PORT_EN
                        r_memWe    <= 1'b1;
                        r_memAddr  <= r_player;
                        r_memWdata <= w_record;
`endif
                    end
                end
                STORE: begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (r_player == ADDR_W'(i)) begin
                            r_mem[(NUM_PLAYERS-1-i)*REC_W +: REC_W] <= w_record;
                        end
                    end
                    if (r_player == ADDR_W'(NUM_PLAYERS - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_player <= r_player + 1'b1;
                        r_state  <= LOAD;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.starting_memory = r_mem;
`ifdef MEM_WRITE_PORT_EN
    assign bus.mem_we          = r_memWe;
    assign bus.mem_addr        = r_memAddr;
    assign bus.mem_wdata       = r_memWdata;
`endif

endmodule

// File: tb/tb_player_memory_init.sv
// Bench for player_memory_init: three parameterisations against a reference
// model of the Pearson key derivation; MEM_WRITE_PORT_EN adds write-port checks.
module tb_player_memory_init;

    logic          clock;
    logic          reset;
    logic [287:0]  tbTable;
    logic [15:0]   keysA;
    logic [15:0]   keysB;
    logic [31:0]   keysC;
    logic          startA;
    logic          startB;
    logic          startC;
    int            checks;
    int            errors;
    int            cycleCount;

    player_memory_init_if #(.NUM_PLAYERS(2), .TABLE_DEPTH(36)) ifA ();
    player_memory_init_if #(.NUM_PLAYERS(2), .TABLE_DEPTH(36)) ifB ();
    player_memory_init_if #(.NUM_PLAYERS(4), .TABLE_DEPTH(36)) ifC ();

    assign ifA.random_table = tbTable;
    assign ifB.random_table = tbTable;
    assign ifC.random_table = tbTable;
    assign ifA.private_keys = keysA;
    assign ifB.private_keys = keysB;
    assign ifC.private_keys = keysC;
    assign ifA.start        = startA;
    assign ifB.start        = startB;
    assign ifC.start        = startC;

    player_memory_init #(.NUM_PLAYERS(2), .TABLE_DEPTH(36), .HASH_ROUNDS(8)) dutA (
        .clock (clock),
        .reset (reset),
        .bus   (ifA.slave)
    );

    player_memory_init #(.NUM_PLAYERS(2), .TABLE_DEPTH(36), .HASH_ROUNDS(1)) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (ifB.slave)
    );

    player_memory_init #(.NUM_PLAYERS(4), .TABLE_DEPTH(36), .HASH_ROUNDS(3)) dutC (
        .clock (clock),
        .reset (reset),
        .bus   (ifC.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

`ifdef MEM_WRITE_PORT_EN
    typedef struct {
        int          t;
        logic [1:0]  addr;
        logic [23:0] data;
    } wePulseT;
    wePulseT weQ [$];

    always @(negedge clock) begin
        if (ifC.mem_we === 1'b1) weQ.push_back('{cycleCount, ifC.mem_addr, ifC.mem_wdata});
    end
`endif

    // busy and done must never be high together on any instance.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            checks++;
            assert (((ifA.busy & ifA.done) | (ifB.busy & ifB.done) | (ifC.busy & ifC.done)) === 1'b0)
            else begin
                errors++;
                $error("[TB] FAIL busyDoneExclusive: observed A=%b%b B=%b%b C=%b%b expected never both high",
                       ifA.busy, ifA.done, ifB.busy, ifB.done, ifC.busy, ifC.done);
            end
        end
    end

    function automatic logic [7:0] modelPub(input logic [7:0] key, input int rounds);
        int h;
        h = 0;
        for (int r = 0; r < rounds; r++) begin
            h = tbTable[(((h ^ int'(key) ^ (r % 256)) % 36) * 8) +: 8];
        end
        return 8'(h);
    endfunction

    function automatic logic [127:0] modelMemory(input logic [31:0] keys, input int n, input int rounds);
        logic [127:0] mem;
        logic [7:0]   k;
        mem = '0;
        for (int i = 0; i < n; i++) begin
            k   = keys[8*(n-1-i) +: 8];
            mem = (mem << 24) | {104'd0, k, modelPub(k, rounds), 8'h32};
        end
        return mem;
    endfunction

    function automatic logic doneOf(input int sel);
        case (sel)
            0:       return ifA.done;
            1:       return ifB.done;
            default: return ifC.done;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int sel);
        @(negedge clock);
        case (sel)
            0:       startA = 1'b1;
            1:       startB = 1'b1;
            default: startC = 1'b1;
        endcase
        @(posedge clock);
        #1;
        startA = 1'b0;
        startB = 1'b0;
        startC = 1'b0;
    endtask

    task automatic waitDone(input int sel, input bit disturb, output int cycles);
        cycles = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clock);
            #1;
            cycles++;
            if (disturb && cycles == 4) begin
                keysA  = 16'($urandom);
                startA = 1'b1;
            end
            if (disturb && cycles == 5) startA = 1'b0;
            if (doneOf(sel) === 1'b1) break;
        end
    endtask

    task automatic randomTable();
        for (int i = 0; i < 36; i++) tbTable[i*8 +: 8] = 8'($urandom);
    endtask

    int          cyc;
    logic [15:0] savedKeys;
    logic [127:0] expMem;

    initial begin
        checks = 0;
        errors = 0;
        cycleCount = 0;
        reset  = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        startC = 1'b0;
        keysA  = '0;
        keysB  = '0;
        keysC  = '0;
        tbTable = '0;

        #3 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("resetStateA", {ifA.busy, ifA.done, ifA.starting_memory}, '0);
        checkOutput("resetStateC", {ifC.busy, ifC.done, ifC.starting_memory}, '0);
        @(negedge clock) reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            checkOutput("idleHoldA", {ifA.busy, ifA.done, ifA.starting_memory}, '0);
        end
        checkOutput("idleHoldB", {ifB.busy, ifB.done, ifB.starting_memory}, '0);

        for (int i = 0; i < 36; i++) tbTable[i*8 +: 8] = 8'hA5;
        keysA = 16'h751B;
        applyStimulus(0);
        checkOutput("busyRiseConst", {ifA.busy, ifA.done}, 2'b10);
        waitDone(0, 1'b0, cyc);
        checkOutput("doneTimeConst", cyc, 20);
        checkOutput("memConst", ifA.starting_memory, 48'h75A5321BA532);

        for (int i = 0; i < 36; i++) tbTable[i*8 +: 8] = 8'(i);
        keysB = 16'h751B;
        applyStimulus(1);
        waitDone(1, 1'b0, cyc);
        checkOutput("doneTimeIdentity", cyc, 6);
        checkOutput("memIdentity", ifB.starting_memory, 48'h7509321B1B32);

        for (int it = 0; it < 3; it++) begin
            randomTable();
            keysA = 16'($urandom);
            savedKeys = keysA;
            applyStimulus(0);
            checkOutput("restartFromDone", {ifA.busy, ifA.done}, 2'b10);
            waitDone(0, it == 1, cyc);
            checkOutput(it == 1 ? "doneTimeDisturbed" : "doneTimeRandom", cyc, 20);
            checkOutput(it == 1 ? "memDisturbed" : "memRandom", ifA.starting_memory,
                        modelMemory({16'd0, savedKeys}, 2, 8));
        end

        keysB = 16'($urandom);
        applyStimulus(1);
        waitDone(1, 1'b0, cyc);
        checkOutput("memRandomB", ifB.starting_memory, modelMemory({16'd0, keysB}, 2, 1));

        keysA = 16'($urandom);
        applyStimulus(0);
        repeat (19) @(posedge clock);
        #1;
        checkOutput("beforeMidReset", {ifA.busy, ifA.done}, 2'b10);
        #2 reset = 1'b1;
        #1;
        checkOutput("midRunReset", {ifA.busy, ifA.done, ifA.starting_memory}, '0);
        @(negedge clock) reset = 1'b0;
        applyStimulus(0);
        waitDone(0, 1'b0, cyc);
        checkOutput("doneTimeAfterReset", cyc, 20);
        checkOutput("memAfterReset", ifA.starting_memory, modelMemory({16'd0, keysA}, 2, 8));

`ifdef MEM_WRITE_PORT_EN
        weQ.delete();
`endif
        randomTable();
        keysC = $urandom;
        expMem = modelMemory(keysC, 4, 3);
        applyStimulus(2);
        waitDone(2, 1'b0, cyc);
        checkOutput("doneTimeC", cyc, 20);
        checkOutput("memC", ifC.starting_memory, expMem);
`ifdef MEM_WRITE_PORT_EN
        @(posedge clock);
        #1;
        checkOutput("memWeCount", weQ.size(), 4);
        for (int i = 0; i < weQ.size() && i < 4; i++) begin
            checkOutput("memWeAddr", weQ[i].addr, i);
            checkOutput("memWeData", weQ[i].data, expMem[(3-i)*24 +: 24]);
            if (i > 0) checkOutput("memWeSpacing", weQ[i].t - weQ[i-1].t, 5);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
